// File: rtl/ac_mem_writer.sv
// Store path from the 19-bit accumulator to byte-wide data memory.
// Writes one saturated pixel byte or three little-endian bytes over a we/ack handshake.
module ac_mem_writer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [18:0]       data_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              mem_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              busy,
    output logic              done
);

    localparam int DATA_W = 19;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_base;
    logic                r_mode;
    logic [1:0]          r_idx;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_data;
    logic                r_busy;
    logic                r_done;

    logic                w_last;
    logic [1:0]          w_idx_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;

    // Pixel downsample output: anything above one byte clips to full scale.
    function automatic logic [7:0] f_sat_u8(input logic [DATA_W-1:0] v);
        return (v > DATA_W'(255)) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic [7:0] f_byte(input logic [DATA_W-1:0] v,
                                          input logic              m,
                                          input logic [1:0]        idx);
        logic [7:0] b;
        if (!m) begin
            b = f_sat_u8(v);
        end else begin
            case (idx)
                2'd0:    b = v[7:0];
                2'd1:    b = v[15:8];
                default: b = {5'b0, v[18:16]};
            endcase
        end
        return b;
    endfunction

    assign w_last     = r_mode ? (r_idx == 2'd2) : 1'b1;
    assign w_idx_nxt  = r_idx + 2'd1;
    // Address arithmetic wraps naturally at the ADDR_W boundary.
    assign w_addr_nxt = r_base + {{(ADDR_W-2){1'b0}}, w_idx_nxt};

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_base     <= '0;
            r_mode     <= 1'b0;
            r_idx      <= 2'd0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (start) begin
                        r_data     <= data_in;
                        r_base     <= addr_in;
                        r_mode     <= mode;
                        r_idx      <= 2'd0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= addr_in;
                        r_mem_data <= f_byte(data_in, mode, 2'd0);
                        r_busy     <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        if (w_last) begin
                            r_mem_we <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_mem_addr <= w_addr_nxt;
                            r_mem_data <= f_byte(r_data, r_mode, w_idx_nxt);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
